gx_rst_ctrl: RTL and testbench
==============================

// Module: gx_rst_ctrl
// PURPOSE
//  Cyclone 10 GX transceiver reset sequencer; the producer side of the GX reset interface consumed by top_pcs
//  (pll_powerdown, tx/rx analog+digital resets, tx/rx ready). Drives the PLL and GX lanes through the
//  Intel-mandated power-up/lock sequence and recovers from loss of lock. Runs on the 50 MHz management clock.
//  Two independent FSMs (TX, RX) share a single clock and reset. All status inputs are asynchronous.
// PARAMETERS
//  T_PLL_PD_CYC   50     min pll_powerdown assertion, cycles (1 us @50 MHz)
//  T_TX_DIG_CYC   4      cycles from tx_analogreset release to tx_digitalreset release
//  T_RX_ANA_CYC   4      min rx_analogreset assertion, cycles
//  T_RX_LTD_CYC   250    rx_is_lockedtodata must be continuously high this many cycles (5 us)
//  T_RX_TO_CYC    50000  CDR lock timeout before analog reset is re-applied (1 ms)
//  SYNC_N         2      synchronizer flops per async input (>=2)
// PORTS
//  clk                  in   1  management clock (50 MHz)
//  nreset               in   1  async active-low reset
//  pll_locked_i         in   1  async; AND of all PLLs feeding the lanes
//  tx_cal_busy_i        in   1  async; OR of PLL + TX lane cal_busy
//  rx_cal_busy_i        in   1  async; OR of RX lane cal_busy
//  rx_is_lockedtodata_i in   1  async; AND over lanes
//  pll_powerdown_o      out  1  PLL powerdown
//  tx_analogreset_o     out  1
//  tx_digitalreset_o    out  1
//  tx_ready_o           out  1  TX lanes usable
//  rx_analogreset_o     out  1
//  rx_digitalreset_o    out  1
//  rx_ready_o           out  1  RX lanes usable
// BEHAVIOUR
//  Reset (nreset=0, async): pll_powerdown=1, all analog/digital resets=1, both ready=0; FSMs in first state; counters 0.
//  All four async inputs pass through SYNC_N flops (sampled values below are synchronized; latency SYNC_N).
//  Outputs are registered directly from state; no combinational paths from inputs.
//  TX FSM:
//   TX_PD      : pd=1, ana=1, dig=1. Count T_PLL_PD_CYC -> TX_WAIT.
//   TX_WAIT    : pd=0, ana=1, dig=1. pll_locked & !tx_cal_busy -> TX_ANA_REL (counter cleared).
//   TX_ANA_REL : ana=0, dig=1. Count T_TX_DIG_CYC -> TX_READY; pll_locked low -> TX_WAIT.
//   TX_READY   : dig=0, ready=1. pll_locked low -> TX_WAIT (ana,dig reassert and ready drops on the same edge).
//   tx_cal_busy rising in TX_ANA_REL/TX_READY -> TX_WAIT.
//  RX FSM (starts only once TX has left TX_PD; rx_ready never precedes pd=0):
//   RX_ANA     : ana=1, dig=1. Count >= T_RX_ANA_CYC and !rx_cal_busy -> RX_WAIT_CDR.
//   RX_WAIT_CDR: ana=0, dig=1. Run-length counter of consecutive ltd=1; cleared on any ltd=0.
//                run == T_RX_LTD_CYC -> RX_READY. Timeout counter == T_RX_TO_CYC -> RX_ANA.
//   RX_READY   : dig=0, ready=1. ltd low -> RX_WAIT_CDR (dig=1, ready=0 next edge; counters cleared).
//   rx_cal_busy high in RX_WAIT_CDR/RX_READY -> RX_ANA.
//  Simultaneous events: loss/cal_busy take priority over count completion in the same cycle.
//  Counters saturate and never wrap. Width = $clog2(max param + 1).
//  The TX and RX FSMs are independent after start-up; an RX relock never disturbs the TX outputs.
//  nreset asserted mid-sequence: immediate return to the reset values above. No sticky state.
// STRUCTURE
//  gx_rst_pkg: tx_state_e, rx_state_e enums; default timing constants.
//  Sub-module gx_rst_sync: SYNC_N-flop bit synchronizer (async active-low reset, reset value 0), one per async input.
//  Top level: two FSMs plus three counters (TX shared, RX run-length, RX timeout).
// TESTING
//  Power-up: release nreset, lock=1 at cycle 10, cal_busy=0 -> pd falls at 50, tx_ana falls ~50+SYNC_N+1,
//    tx_dig and tx_ready change 4 cycles later.
//  TX cal_busy held high for 200 cycles after lock -> tx_ana stays 1 until cal_busy (sync) falls, then normal sequence.
//  RX: ltd toggles low once at run=100 -> run-length restarts; rx_ready rises exactly 250 cycles after the final ltd rise.
//  ltd never asserts -> rx_ana reasserts at 50000 cycles in WAIT_CDR, held >=4 cycles, then retry.
//  In READY, drop pll_locked for 1 cycle -> tx_ready=0, ana/dig=1, full re-sequence; RX outputs unaffected.
//  nreset pulse during RX_WAIT_CDR -> all outputs return to reset values asynchronously; SVA checks dig never releases before ana.

Source files
------------

// File: rtl/gx_rst_pkg.sv
// Shared types and default timing for the GX transceiver reset sequencer.
package gx_rst_pkg;

  typedef enum logic [1:0] {
    TX_PD,
    TX_WAIT,
    TX_ANA_REL,
    TX_READY
  } tx_state_e;

  typedef enum logic [1:0] {
    RX_ANA,
    RX_WAIT_CDR,
    RX_READY
  } rx_state_e;

  // Default timing at the 50 MHz management clock
  localparam int T_PLL_PD_CYC_DEF = 50;
  localparam int T_TX_DIG_CYC_DEF = 4;
  localparam int T_RX_ANA_CYC_DEF = 4;
  localparam int T_RX_LTD_CYC_DEF = 250;
  localparam int T_RX_TO_CYC_DEF  = 50000;
  localparam int SYNC_N_DEF       = 2;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/gx_rst_sync.sv
// Multi-flop bit synchronizer for an asynchronous status input; clears to 0 on reset.
module gx_rst_sync #(
  parameter int SYNC_N = 2
) (
  input  logic clk,
  input  logic nreset,
  input  logic d,
  output logic q
);

  logic [SYNC_N-1:0] chain;

  // Shift the async input through SYNC_N flops
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) chain <= '0;
    else         chain <= {chain[SYNC_N-2:0], d};
  end

  assign q = chain[SYNC_N-1];

endmodule

// File: rtl/gx_rst_ctrl.sv
// Cyclone 10 GX reset sequencer: PLL powerdown, TX and RX analog/digital resets
// and ready flags. Two FSMs share the clock; every output is a register.
module gx_rst_ctrl
  import gx_rst_pkg::*;
#(
  parameter int T_PLL_PD_CYC = T_PLL_PD_CYC_DEF,
  parameter int T_TX_DIG_CYC = T_TX_DIG_CYC_DEF,
  parameter int T_RX_ANA_CYC = T_RX_ANA_CYC_DEF,
  parameter int T_RX_LTD_CYC = T_RX_LTD_CYC_DEF,
  parameter int T_RX_TO_CYC  = T_RX_TO_CYC_DEF,
  parameter int SYNC_N       = SYNC_N_DEF
) (
  input  logic clk,
  input  logic nreset,
  input  logic pll_locked_i,
  input  logic tx_cal_busy_i,
  input  logic rx_cal_busy_i,
  input  logic rx_is_lockedtodata_i,
  output logic pll_powerdown_o,
  output logic tx_analogreset_o,
  output logic tx_digitalreset_o,
  output logic tx_ready_o,
  output logic rx_analogreset_o,
  output logic rx_digitalreset_o,
  output logic rx_ready_o
);

  localparam int TX_W  = $clog2(max_int(T_PLL_PD_CYC, T_TX_DIG_CYC) + 1);
  localparam int RUN_W = $clog2(T_RX_LTD_CYC + 1);
  localparam int TO_W  = $clog2(max_int(T_RX_TO_CYC, T_RX_ANA_CYC) + 1);

  localparam logic [TX_W-1:0]  PD_LAST  = TX_W'(T_PLL_PD_CYC - 1);
  localparam logic [TX_W-1:0]  DIG_LAST = TX_W'(T_TX_DIG_CYC - 1);
  localparam logic [RUN_W-1:0] LTD_RUN  = RUN_W'(T_RX_LTD_CYC);
  localparam logic [TO_W-1:0]  ANA_MIN  = TO_W'(T_RX_ANA_CYC);
  localparam logic [TO_W-1:0]  TO_MAX   = TO_W'(T_RX_TO_CYC);

  function automatic logic [TX_W-1:0] tx_sat_inc(input logic [TX_W-1:0] v);
    return (v == '1) ? v : v + TX_W'(1);
  endfunction

  function automatic logic [RUN_W-1:0] run_sat_inc(input logic [RUN_W-1:0] v);
    return (v == '1) ? v : v + RUN_W'(1);
  endfunction

  function automatic logic [TO_W-1:0] to_sat_inc(input logic [TO_W-1:0] v);
    return (v == '1) ? v : v + TO_W'(1);
  endfunction

  logic pll_locked, tx_cal_busy, rx_cal_busy, rx_ltd;

  gx_rst_sync #(.SYNC_N(SYNC_N)) u_sync_lock (
    .clk(clk), .nreset(nreset), .d(pll_locked_i), .q(pll_locked));
  gx_rst_sync #(.SYNC_N(SYNC_N)) u_sync_txcal (
    .clk(clk), .nreset(nreset), .d(tx_cal_busy_i), .q(tx_cal_busy));
  gx_rst_sync #(.SYNC_N(SYNC_N)) u_sync_rxcal (
    .clk(clk), .nreset(nreset), .d(rx_cal_busy_i), .q(rx_cal_busy));
  gx_rst_sync #(.SYNC_N(SYNC_N)) u_sync_ltd (
    .clk(clk), .nreset(nreset), .d(rx_is_lockedtodata_i), .q(rx_ltd));

  tx_state_e        tx_state;
  rx_state_e        rx_state;
  logic [TX_W-1:0]  tx_cnt;
  logic [RUN_W-1:0] run_cnt;
  logic [TO_W-1:0]  to_cnt;
  logic [RUN_W-1:0] run_inc;
  logic [TO_W-1:0]  to_inc;
  logic             tx_started;

  assign run_inc    = run_sat_inc(run_cnt);
  assign to_inc     = to_sat_inc(to_cnt);
  // RX sequencing is held off until the PLL has been powered up
  assign tx_started = (tx_state != TX_PD);

  // TX FSM: PLL powerdown, wait for lock/cal, staged analog then digital release.
  // TX cal_busy can only be seen rising in ANA_REL/READY since both are entered with it low.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      tx_state          <= TX_PD;
      tx_cnt            <= '0;
      pll_powerdown_o   <= 1'b1;
      tx_analogreset_o  <= 1'b1;
      tx_digitalreset_o <= 1'b1;
      tx_ready_o        <= 1'b0;
    end else begin
      case (tx_state)
        TX_PD: begin
          if (tx_cnt == PD_LAST) begin
            tx_state        <= TX_WAIT;
            tx_cnt          <= '0;
            pll_powerdown_o <= 1'b0;
          end else begin
            tx_cnt <= tx_sat_inc(tx_cnt);
          end
        end
        TX_WAIT: begin
          if (pll_locked && !tx_cal_busy) begin
            tx_state         <= TX_ANA_REL;
            tx_cnt           <= '0;
            tx_analogreset_o <= 1'b0;
          end
        end
        TX_ANA_REL: begin
          if (!pll_locked || tx_cal_busy) begin
            tx_state          <= TX_WAIT;
            tx_cnt            <= '0;
            tx_analogreset_o  <= 1'b1;
            tx_digitalreset_o <= 1'b1;
            tx_ready_o        <= 1'b0;
          end else if (tx_cnt == DIG_LAST) begin
            tx_state          <= TX_READY;
            tx_cnt            <= '0;
            tx_digitalreset_o <= 1'b0;
            tx_ready_o        <= 1'b1;
          end else begin
            tx_cnt <= tx_sat_inc(tx_cnt);
          end
        end
        TX_READY: begin
          if (!pll_locked || tx_cal_busy) begin
            tx_state          <= TX_WAIT;
            tx_cnt            <= '0;
            tx_analogreset_o  <= 1'b1;
            tx_digitalreset_o <= 1'b1;
            tx_ready_o        <= 1'b0;
          end
        end
        default: tx_state <= TX_PD;
      endcase
    end
  end

  // RX FSM: analog reset hold, CDR lock qualification with timeout, ready tracking
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      rx_state          <= RX_ANA;
      run_cnt           <= '0;
      to_cnt            <= '0;
      rx_analogreset_o  <= 1'b1;
      rx_digitalreset_o <= 1'b1;
      rx_ready_o        <= 1'b0;
    end else begin
      case (rx_state)
        RX_ANA: begin
          if (tx_started) begin
            if (to_cnt >= ANA_MIN && !rx_cal_busy) begin
              rx_state         <= RX_WAIT_CDR;
              run_cnt          <= '0;
              to_cnt           <= '0;
              rx_analogreset_o <= 1'b0;
            end else begin
              to_cnt <= to_inc;
            end
          end
        end
        RX_WAIT_CDR: begin
          if (rx_cal_busy) begin
            rx_state         <= RX_ANA;
            run_cnt          <= '0;
            to_cnt           <= '0;
            rx_analogreset_o <= 1'b1;
          end else if (rx_ltd && run_inc == LTD_RUN) begin
            rx_state          <= RX_READY;
            run_cnt           <= '0;
            to_cnt            <= '0;
            rx_digitalreset_o <= 1'b0;
            rx_ready_o        <= 1'b1;
          end else if (to_inc == TO_MAX) begin
            rx_state         <= RX_ANA;
            run_cnt          <= '0;
            to_cnt           <= '0;
            rx_analogreset_o <= 1'b1;
          end else begin
            run_cnt <= rx_ltd ? run_inc : '0;
            to_cnt  <= to_inc;
          end
        end
        RX_READY: begin
          if (rx_cal_busy) begin
            rx_state          <= RX_ANA;
            run_cnt           <= '0;
            to_cnt            <= '0;
            rx_analogreset_o  <= 1'b1;
            rx_digitalreset_o <= 1'b1;
            rx_ready_o        <= 1'b0;
          end else if (!rx_ltd) begin
            rx_state          <= RX_WAIT_CDR;
            run_cnt           <= '0;
            to_cnt            <= '0;
            rx_digitalreset_o <= 1'b1;
            rx_ready_o        <= 1'b0;
          end
        end
        default: rx_state <= RX_ANA;
      endcase
    end
  end

endmodule

// File: tb/tb_gx_rst_ctrl.sv
// Testbench for gx_rst_ctrl: directed stimulus with a change-driven scoreboard.
// Output vector order: {pd, tx_ana, tx_dig, tx_rdy, rx_ana, rx_dig, rx_rdy}.
module tb_gx_rst_ctrl;

  logic clk = 1'b0;
  logic nreset = 1'b1;
  logic pll_locked_i = 1'b0;
  logic tx_cal_busy_i = 1'b0;
  logic rx_cal_busy_i = 1'b1;
  logic rx_is_lockedtodata_i = 1'b0;
  logic pll_powerdown_o, tx_analogreset_o, tx_digitalreset_o, tx_ready_o;
  logic rx_analogreset_o, rx_digitalreset_o, rx_ready_o;

  gx_rst_ctrl dut (
    .clk(clk),
    .nreset(nreset),
    .pll_locked_i(pll_locked_i),
    .tx_cal_busy_i(tx_cal_busy_i),
    .rx_cal_busy_i(rx_cal_busy_i),
    .rx_is_lockedtodata_i(rx_is_lockedtodata_i),
    .pll_powerdown_o(pll_powerdown_o),
    .tx_analogreset_o(tx_analogreset_o),
    .tx_digitalreset_o(tx_digitalreset_o),
    .tx_ready_o(tx_ready_o),
    .rx_analogreset_o(rx_analogreset_o),
    .rx_digitalreset_o(rx_digitalreset_o),
    .rx_ready_o(rx_ready_o)
  );

  always #5 clk = ~clk;

  localparam logic [6:0] RST_VEC = 7'b1110110;

  logic [6:0] outs;
  assign outs = {pll_powerdown_o, tx_analogreset_o, tx_digitalreset_o, tx_ready_o,
                 rx_analogreset_o, rx_digitalreset_o, rx_ready_o};

  int cyc = 0;
  int checks = 0;
  int errors = 0;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         cyc;
    logic [6:0] vec;
    string      tag;
  } exp_t;

  exp_t exp_q[$];

  task automatic push(input int c, input logic [6:0] v, input string t);
    exp_t e;
    e.cyc = c;
    e.vec = v;
    e.tag = t;
    exp_q.push_back(e);
  endtask

  task automatic wait_to(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  // Monitor: every change of the output vector must match the next expected event
  initial begin
    logic [6:0] prev;
    exp_t e;
    prev = RST_VEC;
    forever begin
      @(negedge clk);
      if (outs !== prev) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_change: got %b at cyc %0d, required no change", outs, cyc);
        end else begin
          e = exp_q.pop_front();
          checks++;
          if (outs !== e.vec) begin
            errors++;
            $display("FAIL %s vec: got %b required %b", e.tag, outs, e.vec);
          end
          checks++;
          if (cyc != e.cyc) begin
            errors++;
            $display("FAIL %s cyc: got %0d required %0d", e.tag, cyc, e.cyc);
          end
        end
        prev = outs;
      end
    end
  end

  // Ordering properties: digital reset never released while analog reset held; RX never ready with PLL down
  a_tx_order: assert property (@(posedge clk) disable iff (!nreset)
    !tx_digitalreset_o |-> !tx_analogreset_o)
    else begin errors++; $display("FAIL tx_order: tx_dig=0 while tx_ana=1"); end
  a_rx_order: assert property (@(posedge clk) disable iff (!nreset)
    !rx_digitalreset_o |-> !rx_analogreset_o)
    else begin errors++; $display("FAIL rx_order: rx_dig=0 while rx_ana=1"); end
  a_rx_pd: assert property (@(posedge clk) disable iff (!nreset)
    rx_ready_o |-> !pll_powerdown_o)
    else begin errors++; $display("FAIL rx_pd: rx_ready=1 while pd=1"); end

  initial begin
    int r, p, n, m, s, k, r2;

    // Reset state
    #1 nreset = 1'b0;
    #2;
    checks++;
    if (outs !== RST_VEC) begin
      errors++;
      $display("FAIL reset_vec: got %b required %b", outs, RST_VEC);
    end
    repeat (3) @(negedge clk);

    // Power-up: lock seen at cycle 10, RX held in analog reset by rx cal_busy
    nreset = 1'b1;
    r = cyc;
    push(r + 50, 7'b0110110, "pu_pd_fall");
    push(r + 51, 7'b0010110, "pu_tx_ana_fall");
    push(r + 55, 7'b0001110, "pu_tx_ready");
    wait_to(r + 9);
    pll_locked_i = 1'b1;
    wait_to(r + 60);

    // RX run-length: ltd high, one-cycle drop at run=100, then ready 250 after final sync rise
    p = cyc;
    push(p + 3,   7'b0001010, "rx_ana_fall");
    push(p + 363, 7'b0001001, "rx_ready");
    rx_cal_busy_i = 1'b0;
    wait_to(p + 10);
    rx_is_lockedtodata_i = 1'b1;
    wait_to(p + 110);
    rx_is_lockedtodata_i = 1'b0;
    wait_to(p + 111);
    rx_is_lockedtodata_i = 1'b1;
    wait_to(p + 370);

    // One-cycle loss of PLL lock in READY: TX re-sequences, RX untouched
    n = cyc;
    push(n + 3, 7'b0110001, "lol_tx_drop");
    push(n + 4, 7'b0010001, "lol_tx_ana_fall");
    push(n + 8, 7'b0001001, "lol_tx_ready");
    pll_locked_i = 1'b0;
    wait_to(n + 1);
    pll_locked_i = 1'b1;
    wait_to(n + 20);

    // TX cal_busy held 200 cycles: analog reset held until it clears
    m = cyc;
    push(m + 3,   7'b0110001, "cal_tx_drop");
    push(m + 203, 7'b0010001, "cal_tx_ana_fall");
    push(m + 207, 7'b0001001, "cal_tx_ready");
    tx_cal_busy_i = 1'b1;
    wait_to(m + 200);
    tx_cal_busy_i = 1'b0;
    wait_to(m + 220);

    // Loss of CDR lock, then timeout with ltd never returning, then retry
    s = cyc;
    push(s + 3,     7'b0001010, "ltd_loss");
    push(s + 50003, 7'b0001110, "cdr_timeout");
    push(s + 50008, 7'b0001010, "cdr_retry");
    rx_is_lockedtodata_i = 1'b0;
    wait_to(s + 50020);

    // Async reset pulse while RX waits for CDR
    @(posedge clk);
    #2;
    k = cyc;
    push(k, RST_VEC, "async_reset");
    nreset = 1'b0;
    #1;
    checks++;
    if (outs !== RST_VEC) begin
      errors++;
      $display("FAIL async_reset_now: got %b required %b", outs, RST_VEC);
    end
    wait_to(k + 3);
    nreset = 1'b1;
    r2 = cyc;
    push(r2 + 50, 7'b0110110, "re_pd_fall");
    push(r2 + 51, 7'b0010110, "re_tx_ana_fall");
    push(r2 + 55, 7'b0001010, "re_tx_ready_rx_ana");
    wait_to(r2 + 70);

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL missing_events: got %0d pending, required 0 (next %s)", exp_q.size(), exp_q[0].tag);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
